// File: rtl/vga_sync_gen_if.sv
// VGA timing bundle: counters, syncs, active-video qualifier and ticks.
interface vga_sync_gen_if;
    logic [9:0] hCount;
    logic [9:0] vCount;
    logic       hSync;
    logic       vSync;
    logic       bright;
    logic       pix_tick;
    logic       frame_tick;

    modport master (
        output hCount, vCount, hSync, vSync, bright, pix_tick, frame_tick
    );

    modport slave (
        input hCount, vCount, hSync, vSync, bright, pix_tick, frame_tick
    );
endinterface

// File: rtl/vga_sync_gen.sv
// 640x480@60 VGA timing generator running from the board clock with an
// internal pixel-enable divider. All outputs are registered.
module vga_sync_gen #(
    parameter int unsigned CLK_DIV     = 4,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_ACT_START = 144,
    parameter int unsigned H_ACT_END   = 784,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_ACT_START = 35,
    parameter int unsigned V_ACT_END   = 515
) (
    input  logic           clk,
    input  logic           rst,
    vga_sync_gen_if.master vga
);

    localparam int unsigned     DivW    = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
    localparam logic [9:0]      HLast   = 10'(H_TOTAL - 1);
    localparam logic [9:0]      VLast   = 10'(V_TOTAL - 1);
    localparam logic [9:0]      HSyncE  = 10'(H_SYNC);
    localparam logic [9:0]      VSyncE  = 10'(V_SYNC);
    localparam logic [9:0]      HActS   = 10'(H_ACT_START);
    localparam logic [9:0]      HActE   = 10'(H_ACT_END);
    localparam logic [9:0]      VActS   = 10'(V_ACT_START);
    localparam logic [9:0]      VActE   = 10'(V_ACT_END);

    logic [DivW-1:0] div_q, div_d;
    logic [9:0]      h_cnt_q, h_cnt_d;
    logic [9:0]      v_cnt_q, v_cnt_d;
    logic            hsync_q, hsync_d;
    logic            vsync_q, vsync_d;
    logic            bright_q, bright_d;
    logic            pix_tick_q, pix_tick_d;
    logic            frame_tick_q, frame_tick_d;

    logic div_wrap;
    logic h_wrap;
    logic v_wrap;

    // Divider and pixel/line counter next state; counters move only on div wrap.
    always_comb begin
        div_wrap = (div_q == DivLast);
        h_wrap   = div_wrap && (h_cnt_q == HLast);
        v_wrap   = h_wrap && (v_cnt_q == VLast);

        div_d = div_wrap ? '0 : div_q + 1'b1;

        h_cnt_d = h_cnt_q;
        if (div_wrap) begin
            h_cnt_d = h_wrap ? 10'd0 : h_cnt_q + 10'd1;
        end

        v_cnt_d = v_cnt_q;
        if (h_wrap) begin
            v_cnt_d = v_wrap ? 10'd0 : v_cnt_q + 10'd1;
        end
    end

    // Derived outputs use next-state counters so they land on the same edge.
    always_comb begin
        hsync_d      = (h_cnt_d >= HSyncE);
        vsync_d      = (v_cnt_d >= VSyncE);
        bright_d     = (h_cnt_d >= HActS) && (h_cnt_d < HActE) &&
                       (v_cnt_d >= VActS) && (v_cnt_d < VActE);
        pix_tick_d   = div_wrap;
        frame_tick_d = v_wrap;
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q        <= '0;
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            hsync_q      <= 1'b0;
            vsync_q      <= 1'b0;
            bright_q     <= 1'b0;
            pix_tick_q   <= 1'b0;
            frame_tick_q <= 1'b0;
        end else begin
            div_q        <= div_d;
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            hsync_q      <= hsync_d;
            vsync_q      <= vsync_d;
            bright_q     <= bright_d;
            pix_tick_q   <= pix_tick_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign vga.hCount     = h_cnt_q;
    assign vga.vCount     = v_cnt_q;
    assign vga.hSync      = hsync_q;
    assign vga.vSync      = vsync_q;
    assign vga.bright     = bright_q;
    assign vga.pix_tick   = pix_tick_q;
    assign vga.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Directed bench: default-timing instance for line/reset behaviour, plus a
// shrunken-timing instance so whole frames fit in a short run.
module tb_vga_sync_gen;

    logic clk;
    logic rst_a;
    logic rst_b;

    int n_checks;
    int n_errors;
    int k;

    vga_sync_gen_if vga_a ();
    vga_sync_gen_if vga_b ();

    vga_sync_gen u_dut_a (
        .clk (clk),
        .rst (rst_a),
        .vga (vga_a)
    );

    // Small frame: 20 px x 12 lines, 2 clk per pixel, active 12x7 pixels.
    vga_sync_gen #(
        .CLK_DIV     (2),
        .H_TOTAL     (20),
        .H_SYNC      (3),
        .H_ACT_START (5),
        .H_ACT_END   (17),
        .V_TOTAL     (12),
        .V_SYNC      (2),
        .V_ACT_START (3),
        .V_ACT_END   (10)
    ) u_dut_b (
        .clk (clk),
        .rst (rst_b),
        .vga (vga_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // Advance n rising edges and park on the following falling edge.
    task automatic step_n(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
    endtask

    task automatic check_a_reset(input string tag);
        check_eq({tag, " hCount"}, vga_a.hCount, 0);
        check_eq({tag, " vCount"}, vga_a.vCount, 0);
        check_eq({tag, " hSync"}, vga_a.hSync, 0);
        check_eq({tag, " vSync"}, vga_a.vSync, 0);
        check_eq({tag, " bright"}, vga_a.bright, 0);
        check_eq({tag, " pix_tick"}, vga_a.pix_tick, 0);
        check_eq({tag, " frame_tick"}, vga_a.frame_tick, 0);
    endtask

    int hs_low;
    int vs_at_6399;
    int ft_seen;
    int bright_cnt;
    int vs_low;
    int ft_cnt;
    int ft_k1;
    int ft_k2;
    int first_rise;
    int first_fall;
    int bad_bright;
    logic prev_bright;

    initial begin
        n_checks = 0;
        n_errors = 0;
        k        = 0;
        rst_a    = 1'b0;
        rst_b    = 1'b0;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check_a_reset("rst_a");
        check_eq("rst_b hSync", vga_b.hSync, 0);
        check_eq("rst_b frame_tick", vga_b.frame_tick, 0);

        // Release A; k counts rising edges since release.
        rst_a = 1'b1;
        k     = 0;
        step_n(3);
        check_eq("k3 pix_tick", vga_a.pix_tick, 0);
        check_eq("k3 hCount", vga_a.hCount, 0);
        step_n(1);
        check_eq("k4 pix_tick", vga_a.pix_tick, 1);
        check_eq("k4 hCount", vga_a.hCount, 1);
        step_n(1);
        check_eq("k5 pix_tick", vga_a.pix_tick, 0);
        check_eq("k5 hCount", vga_a.hCount, 1);
        step_n(3);
        check_eq("k8 pix_tick", vga_a.pix_tick, 1);
        check_eq("k8 hCount", vga_a.hCount, 2);

        step_n(380 - k);
        check_eq("h95 hCount", vga_a.hCount, 95);
        check_eq("h95 hSync", vga_a.hSync, 0);
        step_n(4);
        check_eq("h96 hCount", vga_a.hCount, 96);
        check_eq("h96 hSync", vga_a.hSync, 1);

        step_n(576 - k);
        check_eq("h144v0 hCount", vga_a.hCount, 144);
        check_eq("h144v0 bright", vga_a.bright, 0);

        step_n(3196 - k);
        check_eq("h799 hCount", vga_a.hCount, 799);
        check_eq("h799 vCount", vga_a.vCount, 0);
        step_n(4);
        check_eq("hwrap hCount", vga_a.hCount, 0);
        check_eq("hwrap vCount", vga_a.vCount, 1);
        check_eq("hwrap pix_tick", vga_a.pix_tick, 1);
        check_eq("hwrap hSync", vga_a.hSync, 0);
        check_eq("hwrap frame_tick", vga_a.frame_tick, 0);

        // Line 1 spans samples k=3200..6399.
        hs_low     = 0;
        vs_at_6399 = -1;
        for (int i = 0; i < 3200; i++) begin
            if (!vga_a.hSync) hs_low++;
            if (i == 3199) vs_at_6399 = int'(vga_a.vSync);
            step_n(1);
        end
        check_eq("line hSync low clks", hs_low, 384);
        check_eq("v1 end vSync", vs_at_6399, 0);
        check_eq("v2 vSync", vga_a.vSync, 1);
        check_eq("v2 vCount", vga_a.vCount, 2);

        // Park at hCount=400, vCount=2, div=2 then reset asynchronously.
        step_n(8002 - k);
        check_eq("mid hCount", vga_a.hCount, 400);
        check_eq("mid vCount", vga_a.vCount, 2);
        #1 rst_a = 1'b0;
        #1 check_a_reset("async rst");
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst hold hCount", vga_a.hCount, 0);
        rst_a   = 1'b1;
        k       = 0;
        ft_seen = 0;
        for (int i = 0; i < 4; i++) begin
            step_n(1);
            if (vga_a.frame_tick) ft_seen++;
        end
        check_eq("restart hCount", vga_a.hCount, 1);
        check_eq("restart vCount", vga_a.vCount, 0);
        check_eq("restart frame_tick", ft_seen, 0);

        // Small instance: two full frames (480 clk each).
        rst_b       = 1'b1;
        k           = 0;
        bright_cnt  = 0;
        vs_low      = 0;
        ft_cnt      = 0;
        ft_k1       = -1;
        ft_k2       = -1;
        first_rise  = -1;
        first_fall  = -1;
        bad_bright  = 0;
        prev_bright = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            step_n(1);
            if (vga_b.frame_tick) begin
                ft_cnt++;
                if (ft_k1 < 0) ft_k1 = k;
                else if (ft_k2 < 0) ft_k2 = k;
            end
            if (k >= 480 && k < 960) begin
                if (vga_b.bright) bright_cnt++;
                if (!vga_b.vSync) vs_low++;
            end
            if (vga_b.bright && first_rise < 0) first_rise = k;
            if (!vga_b.bright && prev_bright && first_fall < 0) first_fall = k;
            if (vga_b.bright && (vga_b.vCount < 3 || vga_b.vCount >= 10 ||
                                 vga_b.hCount < 5 || vga_b.hCount >= 17)) bad_bright++;
            prev_bright = vga_b.bright;
        end
        check_eq("B frame_tick count", ft_cnt, 2);
        check_eq("B first frame_tick", ft_k1, 480);
        check_eq("B second frame_tick", ft_k2, 960);
        check_eq("B bright clks/frame", bright_cnt, 168);
        check_eq("B vSync low clks", vs_low, 80);
        check_eq("B bright rise", first_rise, 130);
        check_eq("B bright fall", first_fall, 154);
        check_eq("B bright outside", bad_bright, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
